random_symbol_gen: RTL

- Parametrised LFSR-based random symbol source, e.g. letter codes 0..25 for the game logic.
- Generalises the 8-bit letter LFSR:
  - configurable LFSR width, taps and seed;
  - configurable symbol width and acceptance limit (rejection sampling);
  - runtime seed load and zero-state lockup protection;
  - valid/ready output handshake so consumers can stall without losing or repeating symbols.

---
 rtl/random_symbol_gen.sv | 92 +++++++++
 1 files changed

// File: rtl/random_symbol_gen.sv
// LFSR-based random symbol source with rejection sampling and a valid/ready output.
// Optional macro RANDOM_SYMBOL_NO_REPEAT_EN also rejects a repeat of the last accepted symbol.
module random_symbol_gen #(
  parameter int unsigned        LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0]  SEED      = 16'hACE1,
  parameter int unsigned        SYM_W     = 5,
  parameter int unsigned        SYM_LSB   = 0,
  parameter int unsigned        SYM_LIMIT = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              sym_ready,
  output logic              sym_valid,
  output logic [SYM_W-1:0]  sym,
  output logic [LFSR_W-1:0] lfsr_q
);

  // One extra bit so SYM_LIMIT == 2**SYM_W is representable.
  localparam logic [SYM_W:0] LIM = SYM_LIMIT[SYM_W:0];

  logic [LFSR_W-1:0] r_lfsr;
  logic [SYM_W-1:0]  r_sym;
  logic              r_valid;

  logic [LFSR_W-1:0] w_nxt;
  logic [LFSR_W-1:0] w_step_val;
  logic [LFSR_W-1:0] w_seed_val;
  logic [SYM_W-1:0]  w_cand;
  logic              w_in_range;
  logic              w_accept;
  logic              w_draw;

  assign w_nxt      = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
  assign w_cand     = w_nxt[SYM_LSB +: SYM_W];
  assign w_in_range = ({1'b0, w_cand} < LIM);
  // Never allow the all-zero lockup state, whether from the seed port or the step.
  assign w_step_val = (w_nxt == '0) ? SEED : w_nxt;
  assign w_seed_val = (seed == '0) ? SEED : seed;
  assign w_draw     = en && (!r_valid || sym_ready) && !seed_load;

`ifdef RANDOM_SYMBOL_NO_REPEAT_EN
  logic [SYM_W-1:0] r_last;
  logic             r_first;

  assign w_accept = w_in_range && (r_first || (w_cand != r_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= '0;
      r_first <= 1'b1;
    end else if (seed_load) begin
      r_last  <= '0;
      r_first <= 1'b1;
    end else if (w_draw && w_accept) begin
      r_last  <= w_cand;
      r_first <= 1'b0;
    end
  end
`else
  assign w_accept = w_in_range;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= SEED;
      r_sym   <= '0;
      r_valid <= 1'b0;
    end else if (seed_load) begin
      r_lfsr  <= w_seed_val;
      r_valid <= 1'b0;
    end else if (w_draw) begin
      r_lfsr <= w_step_val;
      if (w_accept) begin
        r_sym   <= w_cand;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (r_valid && sym_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign sym_valid = r_valid;
  assign sym       = r_sym;
  assign lfsr_q    = r_lfsr;

endmodule
